// File: rtl/scan_pkg.sv
// Shared types and constants for the scan sequencer and its dwell counter.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_t;

    localparam int           NUM_LINES  = 16;
    localparam int           LINE_W     = 4;
    localparam logic [3:0]   FIRST_LINE = 4'd0;
    localparam logic [3:0]   LAST_LINE  = 4'd15;

    // Line step in the scan direction; 4-bit arithmetic gives the 15<->0 wrap.
    function automatic logic [LINE_W-1:0] next_line(input logic [LINE_W-1:0] w, input logic dir);
        return dir ? (w - 4'd1) : (w + 4'd1);
    endfunction

endpackage

// File: rtl/scan_dwell_counter.sv
// Loadable down-counter shared by the BLANK and DRIVE phases; freezes on hold.
module scan_dwell_counter #(
    parameter int DWELL_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic [DWELL_W-1:0] load_val_i,
    input  logic               hold_i,
    output logic               zero_o
);

    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (!hold_i && (cnt_q != {DWELL_W{1'b0}})) begin
            cnt_d = cnt_q - {{(DWELL_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= {DWELL_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == {DWELL_W{1'b0}});

endmodule

// File: rtl/scan_sequencer.sv
// Address/enable sequencer for the 4-to-16 decoder; SCAN_REVERSE_EN adds a descending scan (dir_i).
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int DWELL_W   = 8,
    parameter int BLANK_CYC = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               hold_i,
    input  logic               mode_i,
    input  logic [DWELL_W-1:0] dwell_i,
`ifdef SCAN_REVERSE_EN
    input  logic               dir_i,
`endif
    output logic               en_o,
    output logic [3:0]         w_o,
    output logic               busy_o,
    output logic               line_strobe_o,
    output logic               done_o
);

    // Counter reload for a BLANK phase: it expires after BLANK_CYC cycles.
    localparam int BLANK_LD = (BLANK_CYC > 0) ? (BLANK_CYC - 1) : 0;
    localparam logic [DWELL_W-1:0] BLANK_LOAD = DWELL_W'(BLANK_LD);

    scan_state_t        state_q, state_d;
    logic [3:0]         w_q, w_d;
    logic               en_q, en_d;
    logic               strobe_q, strobe_d;
    logic               done_q, done_d;
    logic               mode_q, mode_d;
    logic               dir_q, dir_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               cnt_load_s;
    logic [DWELL_W-1:0] cnt_val_s;
    logic               cnt_zero_s;
    logic               dir_start_s;
    logic [3:0]         end_line_s;

`ifdef SCAN_REVERSE_EN
    assign dir_start_s = dir_i;
`else
    assign dir_start_s = 1'b0;
`endif

    assign end_line_s = dir_q ? FIRST_LINE : LAST_LINE;

    scan_dwell_counter #(.DWELL_W(DWELL_W)) u_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (cnt_load_s),
        .load_val_i (cnt_val_s),
        .hold_i     (hold_i),
        .zero_o     (cnt_zero_s)
    );

    always_comb begin
        state_d    = state_q;
        w_d        = w_q;
        en_d       = en_q;
        strobe_d   = 1'b0;
        done_d     = 1'b0;
        mode_d     = mode_q;
        dir_d      = dir_q;
        dwell_d    = dwell_q;
        cnt_load_s = 1'b0;
        cnt_val_s  = dwell_q;
        if (stop_i && (state_q != IDLE)) begin
            state_d    = IDLE;
            en_d       = 1'b0;
            w_d        = FIRST_LINE;
            cnt_load_s = 1'b1;
            cnt_val_s  = {DWELL_W{1'b0}};
        end else if (hold_i && (state_q != IDLE)) begin
            state_d = state_q;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i && !stop_i) begin
                        mode_d     = mode_i;
                        dir_d      = dir_start_s;
                        dwell_d    = dwell_i;
                        w_d        = dir_start_s ? LAST_LINE : FIRST_LINE;
                        cnt_load_s = 1'b1;
                        if (BLANK_CYC > 0) begin
                            state_d   = BLANK;
                            en_d      = 1'b0;
                            cnt_val_s = BLANK_LOAD;
                        end else begin
                            state_d   = DRIVE;
                            en_d      = 1'b1;
                            strobe_d  = 1'b1;
                            cnt_val_s = dwell_i;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                BLANK: begin
                    if (cnt_zero_s) begin
                        state_d    = DRIVE;
                        en_d       = 1'b1;
                        strobe_d   = 1'b1;
                        cnt_load_s = 1'b1;
                        cnt_val_s  = dwell_q;
                    end else begin
                        state_d = BLANK;
                    end
                end
                DRIVE: begin
                    if (!cnt_zero_s) begin
                        state_d = DRIVE;
                    end else if (mode_q && (w_q == end_line_s)) begin
                        state_d = IDLE;
                        en_d    = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        // Boundary cycle: W may only move here, never mid-dwell.
                        w_d        = next_line(w_q, dir_q);
                        cnt_load_s = 1'b1;
                        if (BLANK_CYC > 0) begin
                            state_d   = BLANK;
                            en_d      = 1'b0;
                            cnt_val_s = BLANK_LOAD;
                        end else begin
                            state_d   = DRIVE;
                            en_d      = 1'b1;
                            strobe_d  = 1'b1;
                            cnt_val_s = dwell_q;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    en_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            w_q      <= FIRST_LINE;
            en_q     <= 1'b0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            mode_q   <= 1'b0;
            dir_q    <= 1'b0;
            dwell_q  <= {DWELL_W{1'b0}};
        end else begin
            state_q  <= state_d;
            w_q      <= w_d;
            en_q     <= en_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
            mode_q   <= mode_d;
            dir_q    <= dir_d;
            dwell_q  <= dwell_d;
        end
    end

    assign en_o          = en_q;
    assign w_o           = w_q;
    assign busy_o        = (state_q != IDLE);
    assign line_strobe_o = strobe_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Scoreboard bench for scan_sequencer: expected line order queued at Start, popped on LineStrobe.
module tb_scan_sequencer;

    logic       clk, rst, start, stop, hold, mode, dir;
    logic [7:0] dwell;
    logic       en, busy, strobe, done;
    logic [3:0] w;
    logic [3:0] exp_q[$];
    int         checks = 0;
    int         passes = 0;

    scan_sequencer #(.DWELL_W(8), .BLANK_CYC(1)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .stop_i        (stop),
        .hold_i        (hold),
        .mode_i        (mode),
        .dwell_i       (dwell),
`ifdef SCAN_REVERSE_EN
        .dir_i         (dir),
`endif
        .en_o          (en),
        .w_o           (w),
        .busy_o        (busy),
        .line_strobe_o (strobe),
        .done_o        (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic do_start(input logic m, input logic [7:0] d, input logic dr);
        start = 1'b1; mode = m; dwell = d; dir = dr;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset;
        checks++; if ({en, w, busy, strobe, done} !== 8'h00) $display("FAIL reset_outputs: got %h expected 00", {en, w, busy, strobe, done}); else passes++;
    endtask

    task automatic test_single_sweep;
        int busy_n = 0, done_n = 0, strobes = 0, en_run = 0;
        logic prev_en = 1'b0;
        logic [3:0] e;
        for (int i = 0; i < 16; i++) exp_q.push_back(4'(i));
        do_start(1'b1, 8'd2, 1'b0);
        checks++; if ({busy, en} !== 2'b10) $display("FAIL start_latency_blank: got busy/en %b expected 10", {busy, en}); else passes++;
        for (int cyc = 0; cyc < 70; cyc++) begin
            if (busy) busy_n++;
            if (done) done_n++;
            if (cyc == 1) begin
                checks++; if ({en, strobe} !== 2'b11) $display("FAIL first_en_latency: got en/strobe %b expected 11", {en, strobe}); else passes++;
            end
            if (en) en_run++;
            else if (prev_en) begin
                checks++; if (en_run != 3) $display("FAIL single_dwell_len: got %0d expected 3", en_run); else passes++;
                en_run = 0;
            end
            if (strobe) begin
                strobes++;
                checks++;
                if (exp_q.size() == 0) $display("FAIL single_extra_strobe: got w=%0d expected none", w);
                else begin
                    e = exp_q.pop_front();
                    if (w !== e) $display("FAIL single_line: got %0d expected %0d", w, e); else passes++;
                end
            end
            prev_en = en;
            @(negedge clk);
        end
        checks++; if (strobes != 16) $display("FAIL single_strobes: got %0d expected 16", strobes); else passes++;
        checks++; if (done_n != 1) $display("FAIL single_done: got %0d expected 1", done_n); else passes++;
        checks++; if (busy_n != 64) $display("FAIL single_busy: got %0d expected 64", busy_n); else passes++;
        checks++; if (exp_q.size() != 0) $display("FAIL single_queue: got %0d expected 0", exp_q.size()); else passes++;
        exp_q.delete();
    endtask

    task automatic test_continuous;
        int done_n = 0;
        logic [3:0] e;
        for (int i = 0; i < 20; i++) exp_q.push_back(4'(i % 16));
        do_start(1'b0, 8'd0, 1'b0);
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (done) done_n++;
            if (strobe) begin
                checks++;
                if (exp_q.size() == 0) $display("FAIL cont_extra_strobe: got w=%0d expected none", w);
                else begin
                    e = exp_q.pop_front();
                    if ({en, w} !== {1'b1, e}) $display("FAIL cont_line: got en/w %0d/%0d expected 1/%0d", en, w, e); else passes++;
                end
            end
            @(negedge clk);
        end
        checks++; if (exp_q.size() != 0) $display("FAIL cont_queue: got %0d expected 0", exp_q.size()); else passes++;
        checks++; if (done_n != 0) $display("FAIL cont_done: got %0d expected 0", done_n); else passes++;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        checks++; if ({en, w, busy, done} !== 7'b0) $display("FAIL cont_stop: got en/w/busy/done %b expected 0000000", {en, w, busy, done}); else passes++;
        exp_q.delete();
    endtask

    task automatic test_hold;
        int done_n = 0, l7 = 0, hold_left = 0;
        logic [3:0] e;
        for (int i = 0; i < 16; i++) exp_q.push_back(4'(i));
        do_start(1'b1, 8'd3, 1'b0);
        for (int cyc = 0; cyc < 200 && done_n == 0; cyc++) begin
            if (done) done_n++;
            if (en && w == 4'd7) l7++;
            if (hold_left > 0) begin
                checks++; if ({en, w, strobe} !== 6'b1_0111_0) $display("FAIL hold_frozen: got en/w/strobe %b expected 101110", {en, w, strobe}); else passes++;
                hold_left--;
                if (hold_left == 0) hold = 1'b0;
            end
            if (strobe) begin
                checks++;
                if (exp_q.size() == 0) $display("FAIL hold_extra_strobe: got w=%0d expected none", w);
                else begin
                    e = exp_q.pop_front();
                    if (w !== e) $display("FAIL hold_line: got %0d expected %0d", w, e); else passes++;
                end
                if (w == 4'd7) begin hold = 1'b1; hold_left = 5; end
            end
            @(negedge clk);
        end
        checks++; if (l7 != 9) $display("FAIL hold_line7_cycles: got %0d expected 9", l7); else passes++;
        checks++; if (done_n != 1) $display("FAIL hold_done: got %0d expected 1", done_n); else passes++;
        checks++; if (exp_q.size() != 0) $display("FAIL hold_queue: got %0d expected 0", exp_q.size()); else passes++;
        hold = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_start_stop;
        int busy_n = 0, done_n = 0;
        logic [3:0] e;
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        checks++; if ({busy, en} !== 2'b00) $display("FAIL start_stop_idle: got busy/en %b expected 00", {busy, en}); else passes++;
        for (int i = 0; i < 16; i++) exp_q.push_back(4'(i));
        do_start(1'b1, 8'd1, 1'b0);
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (cyc == 10) begin start = 1'b1; dwell = 8'd5; mode = 1'b0; end
            if (cyc == 11) start = 1'b0;
            if (busy) busy_n++;
            if (done) done_n++;
            if (strobe) begin
                checks++;
                if (exp_q.size() == 0) $display("FAIL busy_start_extra_strobe: got w=%0d expected none", w);
                else begin
                    e = exp_q.pop_front();
                    if (w !== e) $display("FAIL busy_start_line: got %0d expected %0d", w, e); else passes++;
                end
            end
            @(negedge clk);
        end
        checks++; if (busy_n != 48) $display("FAIL busy_start_busy: got %0d expected 48", busy_n); else passes++;
        checks++; if (done_n != 1) $display("FAIL busy_start_done: got %0d expected 1", done_n); else passes++;
        checks++; if (exp_q.size() != 0) $display("FAIL busy_start_queue: got %0d expected 0", exp_q.size()); else passes++;
        exp_q.delete();
    endtask

    task automatic test_async_reset;
        logic found = 1'b0;
        logic [3:0] e;
        do_start(1'b0, 8'd3, 1'b0);
        for (int cyc = 0; cyc < 100 && !found; cyc++) begin
            if (strobe && w == 4'd9) found = 1'b1;
            else @(negedge clk);
        end
        checks++; if (!found) $display("FAIL reset_reach_line9: got timeout expected line 9"); else passes++;
        #2 rst = 1'b1;
        #1;
        checks++; if ({en, w, busy} !== 6'b0) $display("FAIL async_reset: got en/w/busy %b expected 000000", {en, w, busy}); else passes++;
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(4'd0);
        do_start(1'b1, 8'd0, 1'b0);
        found = 1'b0;
        for (int cyc = 0; cyc < 5 && !found; cyc++) begin
            if (strobe) begin
                found = 1'b1;
                e = exp_q.pop_front();
                checks++; if (w !== e) $display("FAIL restart_line: got %0d expected %0d", w, e); else passes++;
            end else @(negedge clk);
        end
        checks++; if (!found) $display("FAIL restart_strobe: got timeout expected strobe"); else passes++;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        exp_q.delete();
    endtask

`ifdef SCAN_REVERSE_EN
    task automatic test_reverse;
        int done_n = 0;
        logic [3:0] e;
        for (int i = 15; i >= 0; i--) exp_q.push_back(4'(i));
        do_start(1'b1, 8'd1, 1'b1);
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (done) done_n++;
            if (strobe) begin
                checks++;
                if (exp_q.size() == 0) $display("FAIL rev_extra_strobe: got w=%0d expected none", w);
                else begin
                    e = exp_q.pop_front();
                    if (w !== e) $display("FAIL rev_line: got %0d expected %0d", w, e); else passes++;
                end
            end
            @(negedge clk);
        end
        checks++; if (done_n != 1) $display("FAIL rev_done: got %0d expected 1", done_n); else passes++;
        checks++; if (exp_q.size() != 0) $display("FAIL rev_queue: got %0d expected 0", exp_q.size()); else passes++;
        dir = 1'b0;
        exp_q.delete();
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0;
        mode = 1'b0; dir = 1'b0; dwell = 8'd0;
        repeat (2) @(negedge clk);
        test_reset;
        rst = 1'b0;
        @(negedge clk);
        test_single_sweep;
        test_continuous;
        test_hold;
        test_start_stop;
        test_async_reset;
`ifdef SCAN_REVERSE_EN
        test_reverse;
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
- Upstream address/enable generator for the team's 4-to-16 active-low line decoder.
- On a Start request it steps W through lines 0..15 (or 15..0). Each line is held with En=1 for a programmable dwell time.
- A break-before-make blanking gap with En=0 separates consecutive lines.
- Supports continuous or single-sweep operation, with pause (Hold) and abort (Stop).

Parameters:
- DWELL_W, 8, width of the Dwell input and of the internal dwell counter.
- BLANK_CYC, 1, number of En=0 cycles between lines; legal range 0..15; 0 means no gap.

Ports:
- Clock  input  1  single system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  sweep request; sampled only in IDLE.
- Stop  input  1  abort request; honoured in any state.
- Hold  input  1  pause; freezes the dwell/blank counters and W.
- Mode  input  1  0 = continuous wrap, 1 = single sweep; latched at Start.
- Dwell  input  DWELL_W  line hold time = Dwell+1 cycles; latched at Start.
- En  output  1  decoder enable; registered.
- W  output  4  decoder line select; registered.
- Busy  output  1  high whenever state != IDLE.
- LineStrobe  output  1  one-cycle pulse in the first DRIVE cycle of each line.
- Done  output  1  one-cycle pulse on completion of a single sweep.

Behaviour:
- Reset (async) values: state=IDLE, En=0, W=4'd0, Busy=0, LineStrobe=0, Done=0, counters=0.
- States: IDLE, BLANK, DRIVE.
- IDLE:
  - Start=1 and Stop=0 → latch Dwell and Mode, load W=0 (first line).
  - Go to BLANK if BLANK_CYC>0, otherwise go to DRIVE.
- BLANK:
  - En=0, W holds the next line; lasts BLANK_CYC cycles, then DRIVE.
- DRIVE:
  - En=1 for exactly Dwell+1 cycles; Dwell=0 gives a 1-cycle line.
  - LineStrobe=1 in the first DRIVE cycle only.
- End of DRIVE on the last line (15 ascending), single mode: go to IDLE, En=0; Done=1 for one cycle in the first IDLE cycle.
- End of DRIVE otherwise:
  - W steps to the next line, with wrap-around 15→0 (or 0→15 in reverse).
  - Go to BLANK (or directly to DRIVE if BLANK_CYC=0).
- W changes only while En=0, or on the boundary cycle when BLANK_CYC=0. It never changes mid-dwell.
- Latency: with BLANK_CYC=1, Start sampled at edge k gives BLANK at k+1 and first En=1 at k+2.
- Single-sweep length: 16*(BLANK_CYC+Dwell+1) cycles from the first non-IDLE cycle to the last DRIVE cycle.
- Hold=1: all counters, W, state and En are frozen; LineStrobe and Done are not re-issued. Stop overrides Hold.
- Stop=1 in any non-IDLE state: next cycle state=IDLE, En=0, W=0, no Done pulse.
- Start and Stop together in IDLE: Stop wins and the block stays IDLE.
- Start while Busy: ignored. Dwell and Mode changes while Busy: ignored until the next Start.
- Reset asserted mid-sweep: immediate asynchronous return to reset values; En drops without waiting for a clock edge.

Optional Feature:
- Macro SCAN_REVERSE_EN.
- Defined: adds input port Dir (1 bit), latched at Start.
  - Dir=1 scans 15→14→…→0; first line is 15, last line is 0, wrap is 0→15.
  - Dir=0 behaves as ascending.
- Undefined: no Dir port; ascending scan only; logic is identical to the Dir=0 case.

Decomposition:
- Package scan_pkg:
  - state enum scan_state_t {IDLE, BLANK, DRIVE}.
  - Constants NUM_LINES=16, LINE_W=4, FIRST_LINE=4'd0, LAST_LINE=4'd15.
- One sub-module, scan_dwell_counter:
  - Loadable down-counter of width DWELL_W with Hold (freeze) input and a zero flag.
  - Instantiated once and shared by the BLANK and DRIVE phases.

Test Plan:
- Reset then Start, Mode=1, Dwell=2, BLANK_CYC=1 → W=0..15, each line En=1 for 3 cycles after 1 blank cycle, 16 LineStrobe pulses, Done=1 exactly once, 64 Busy cycles.
- Mode=0, Dwell=0 → after W=15, the sequence goes blank then W=0 with En=1; no Done; continues until Stop, then En=0, W=0 and Busy=0 the next cycle.
- Hold=1 for 5 cycles mid-dwell on W=7 → En and W=7 frozen; the line still totals Dwell+1 active (non-held) cycles; no extra LineStrobe.
- Start and Stop in the same IDLE cycle → stays IDLE, Busy=0. Start pulsed while Busy → no restart; W sequence undisturbed.
- Reset asserted mid-DRIVE on W=9 → En=0 and W=0 immediately (before the next edge); a fresh Start resumes from line 0.
- With SCAN_REVERSE_EN, Dir=1, Mode=1, Dwell=1 → W visits 15 down to 0; Done after the W=0 line.
